// File: rtl/bist_pattern_engine.sv
// -----------------------------------------------------------------------------
// bist_pattern_engine
//
// Built-in stimulus/response engine for combinational (or shallow-pipelined)
// benchmark circuits. A Galois LFSR drives the circuit inputs with a seedable,
// deterministic pattern stream. A MISR compacts the circuit responses into a
// signature. Each run applies a fixed number of patterns under a start/done
// handshake, so one signature compare checks the whole run.
//
// Optional build macro:
//   BIST_GOLDEN_CMP_EN  adds parameter GOLDEN and output pass, a registered
//                       compare of the final signature against GOLDEN.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (priority over abort/start)
//   start        pulse; begins a run when sampled in IDLE or DONE
//   abort        returns to IDLE from any state, partial results kept
//   seed_load    sampled with start: 1 = seed_in, 0 = SEED parameter
//   seed_in      run seed (all-zero is replaced by 1)
//   dut_in       registered stimulus to the circuit under test (LFSR state)
//   dut_out      response from the circuit under test
//   busy         high in RUN and DRAIN
//   done         high in DONE
//   signature    MISR contents
//   pattern_cnt  patterns applied in the current/last run (saturating)
//   pass         (BIST_GOLDEN_CMP_EN only) signature matched GOLDEN at DONE
// -----------------------------------------------------------------------------
module bist_pattern_engine #(
    parameter int               IN_W       = 41,
    parameter int               OUT_W      = 32,
    parameter logic [IN_W-1:0]  POLY       = 'h9,
    parameter logic [OUT_W-1:0] MISR_POLY  = 'h0040_0007,
    parameter int               N_PATTERNS = 1024,
    parameter int               LAT        = 0,
    parameter logic [IN_W-1:0]  SEED       = 'h1
`ifdef BIST_GOLDEN_CMP_EN
    ,
    parameter logic [OUT_W-1:0] GOLDEN     = '0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [IN_W-1:0]  seed_in,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pattern_cnt
`ifdef BIST_GOLDEN_CMP_EN
    ,
    output logic             pass
`endif
);

    // state  | meaning
    // IDLE   | waiting for start, outputs from reset or an aborted run
    // RUN    | one new pattern per cycle, LFSR advancing
    // DRAIN  | LFSR frozen, collecting the last LAT delayed responses
    // DONE   | run complete, signature and pattern_cnt held
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  lfsr_step;
    logic [IN_W-1:0]  seed_sel;
    logic [IN_W-1:0]  seed_eff;
    logic [OUT_W-1:0] misr_step;
    logic [OUT_W-1:0] misr_next;
    logic             last_pat;
    logic             capture;
    logic             drain_last;

    always_comb begin
        lfsr_step = {dut_in[IN_W-2:0], 1'b0} ^ (dut_in[IN_W-1] ? POLY : '0);
        misr_step = {signature[OUT_W-2:0], 1'b0}
                    ^ (signature[OUT_W-1] ? MISR_POLY : '0)
                    ^ dut_out;
        misr_next = capture ? misr_step : signature;
        seed_sel  = seed_load ? seed_in : SEED;
        // A zero seed would lock the LFSR at zero for the whole run.
        seed_eff  = (seed_sel == '0) ? IN_W'(1) : seed_sel;
        last_pat  = (pattern_cnt == 16'(N_PATTERNS - 1));
    end

    // Capture-valid pipeline and drain timer. A pattern applied on a RUN
    // edge produces its response LAT cycles later, so the valid bit marks
    // which edges carry a response worth compacting.
    generate
        if (LAT > 0) begin : g_pipe
            localparam int DW = $clog2(LAT + 1);
            logic [LAT-1:0] valid_sr;
            logic [DW-1:0]  drain_cnt;

            always_ff @(posedge clk) begin
                if (rst || abort) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr <= (valid_sr << 1) | LAT'(state == S_RUN);
                end
            end

            // Down-counter reloaded outside DRAIN; terminal count ends DRAIN.
            always_ff @(posedge clk) begin
                if (rst || state != S_DRAIN) begin
                    drain_cnt <= DW'(LAT - 1);
                end else if (drain_cnt != '0) begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
            end

            assign capture    = valid_sr[LAT-1] && !abort;
            assign drain_last = (drain_cnt == '0);
        end else begin : g_nopipe
            // Purely combinational circuit: the response to the pattern
            // currently on dut_in is captured on the same edge that replaces it.
            assign capture    = (state == S_RUN) && !abort;
            assign drain_last = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            dut_in      <= '0;
            signature   <= '0;
            pattern_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
            pass        <= 1'b0;
`endif
        end else if (abort) begin
            // Partial signature and count stay visible for debug.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
            pass  <= 1'b0;
`endif
        end else begin
            if (capture) begin
                signature <= misr_step;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        dut_in      <= seed_eff;
                        signature   <= '0;
                        pattern_cnt <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
`ifdef BIST_GOLDEN_CMP_EN
                        pass        <= 1'b0;
`endif
                    end
                end

                S_RUN: begin
                    if (pattern_cnt != 16'hFFFF) begin
                        pattern_cnt <= pattern_cnt + 16'd1;
                    end
                    if (last_pat) begin
                        // dut_in keeps the last applied pattern.
                        if (LAT > 0) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef BIST_GOLDEN_CMP_EN
                            pass  <= (misr_next == GOLDEN);
`endif
                        end
                    end else begin
                        dut_in <= lfsr_step;
                    end
                end

                S_DRAIN: begin
                    if (drain_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef BIST_GOLDEN_CMP_EN
                        pass  <= (misr_next == GOLDEN);
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_engine.sv
module tb_bist_pattern_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance A: 4-bit, 15 patterns, combinational CUT -----
    logic        a_start = 0, a_abort = 0, a_seed_load = 0;
    logic [3:0]  a_seed_in = 0, a_dut_in, a_dut_out, a_sig, a_mask = 0;
    logic        a_busy, a_done;
    logic [15:0] a_cnt;
`ifdef BIST_GOLDEN_CMP_EN
    logic        a_pass;
`endif
    assign a_dut_out = cut_a(a_dut_in, a_mask);

    bist_pattern_engine #(
        .IN_W(4), .OUT_W(4), .POLY(4'h3), .MISR_POLY(4'h3),
        .N_PATTERNS(15), .LAT(0), .SEED(4'h1)
    ) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .seed_load(a_seed_load), .seed_in(a_seed_in), .dut_in(a_dut_in),
        .dut_out(a_dut_out), .busy(a_busy), .done(a_done),
        .signature(a_sig), .pattern_cnt(a_cnt)
`ifdef BIST_GOLDEN_CMP_EN
        , .pass(a_pass)
`endif
    );

    // ---------------- instance B: 2 patterns, constant response ------------
    logic        b_start = 0, b_abort = 0;
    logic [3:0]  b_dut_in, b_dut_out = 0, b_sig;
    logic        b_busy, b_done;
    logic [15:0] b_cnt;
`ifdef BIST_GOLDEN_CMP_EN
    logic        b_pass;
`endif

    bist_pattern_engine #(
        .IN_W(4), .OUT_W(4), .POLY(4'h3), .MISR_POLY(4'h3),
        .N_PATTERNS(2), .LAT(0), .SEED(4'h1)
`ifdef BIST_GOLDEN_CMP_EN
        , .GOLDEN(4'h3)
`endif
    ) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .seed_load(1'b0), .seed_in(4'h0), .dut_in(b_dut_in),
        .dut_out(b_dut_out), .busy(b_busy), .done(b_done),
        .signature(b_sig), .pattern_cnt(b_cnt)
`ifdef BIST_GOLDEN_CMP_EN
        , .pass(b_pass)
`endif
    );

    // ---------------- instance C: LAT=2, 3 patterns, pipelined CUT ---------
    logic        c_start = 0, c_abort = 0;
    logic [3:0]  c_dut_in, c_dut_out, c_sig, c_p0 = 0, c_p1 = 0;
    logic        c_busy, c_done;
    logic [15:0] c_cnt;
`ifdef BIST_GOLDEN_CMP_EN
    logic        c_pass;
`endif
    always @(posedge clk) begin
        c_p0 <= c_dut_in;
        c_p1 <= c_p0;
    end
    assign c_dut_out = c_p1;

    bist_pattern_engine #(
        .IN_W(4), .OUT_W(4), .POLY(4'h3), .MISR_POLY(4'h3),
        .N_PATTERNS(3), .LAT(2), .SEED(4'h1)
    ) u_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort),
        .seed_load(1'b0), .seed_in(4'h0), .dut_in(c_dut_in),
        .dut_out(c_dut_out), .busy(c_busy), .done(c_done),
        .signature(c_sig), .pattern_cnt(c_cnt)
`ifdef BIST_GOLDEN_CMP_EN
        , .pass(c_pass)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] cut_a(input logic [3:0] p, input logic [3:0] m);
        return {p[0], p[3:1]} ^ m;
    endfunction

    function automatic logic [3:0] lfsr4(input logic [3:0] l);
        return {l[2:0], 1'b0} ^ (l[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] misr4(input logic [3:0] s, input logic [3:0] d);
        return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0) ^ d;
    endfunction

    // Signature after the first n patterns starting from first, CUT mask m.
    function automatic logic [3:0] model_sig(input logic [3:0] first,
                                             input logic [3:0] m, input int n);
        logic [3:0] l, s;
        l = first;
        s = 4'h0;
        for (int i = 0; i < n; i++) begin
            s = misr4(s, cut_a(l, m));
            l = lfsr4(l);
        end
        return s;
    endfunction

    logic [3:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_dut_in", {28'd0, a_dut_in}, 32'h0);
        chk("rst_sig", {28'd0, a_sig}, 32'h0);
        chk("rst_cnt", {16'd0, a_cnt}, 32'h0);
        chk("rst_busy", {31'd0, a_busy}, 32'h0);
        chk("rst_done", {31'd0, a_done}, 32'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       seed_load;
        logic [3:0] seed_in;
        logic [3:0] mask;
        logic [3:0] exp_first;
        logic       mid_start;
    } vec_a_t;

    typedef struct {
        logic [3:0] resp;
        logic [3:0] exp_sig;
    } vec_b_t;

    vec_a_t va[4];
    vec_b_t vb[5];

    initial begin
        logic [3:0] l;
        logic [3:0] e;

        va[0] = '{1'b0, 4'h7, 4'h0, 4'h1, 1'b0};
        va[1] = '{1'b1, 4'h0, 4'h5, 4'h1, 1'b1};
        va[2] = '{1'b1, 4'hA, 4'hF, 4'hA, 1'b0};
        va[3] = '{1'b1, 4'h6, 4'h3, 4'h6, 1'b1};

        vb[0] = '{4'h1, 4'h3};
        vb[1] = '{4'h0, 4'h0};
        vb[2] = '{4'h2, 4'h6};
        vb[3] = '{4'hF, 4'h2};
        vb[4] = '{4'h8, 4'hB};

        tick();

        // ---- A: pattern sequence, signature, count, hold in DONE ----
        foreach (va[v]) begin
            do_reset();
            a_mask      = va[v].mask;
            a_seed_load = va[v].seed_load;
            a_seed_in   = va[v].seed_in;
            a_start     = 1'b1;
            l = va[v].exp_first;
            for (int i = 0; i < 15; i++) begin
                exp_q.push_back(l);
                l = lfsr4(l);
            end
            tick();
            a_start = 1'b0;
            for (int i = 0; i < 15; i++) begin
                if (exp_q.size() == 0) begin
                    chk("a_queue_underrun", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("a_dut_in", {28'd0, a_dut_in}, {28'd0, e});
                end
                chk("a_busy_run", {31'd0, a_busy}, 32'h1);
                if (va[v].mid_start && i == 5) a_start = 1'b1;
                tick();
                a_start = 1'b0;
            end
            chk("a_done", {31'd0, a_done}, 32'h1);
            chk("a_busy_done", {31'd0, a_busy}, 32'h0);
            chk("a_cnt", {16'd0, a_cnt}, 32'd15);
            chk("a_sig", {28'd0, a_sig}, {28'd0, model_sig(va[v].exp_first, va[v].mask, 15)});
            tick();
            tick();
            chk("a_sig_hold", {28'd0, a_sig}, {28'd0, model_sig(va[v].exp_first, va[v].mask, 15)});
            chk("a_cnt_hold", {16'd0, a_cnt}, 32'd15);
            chk("a_done_hold", {31'd0, a_done}, 32'h1);
        end

        // ---- A: abort at pattern 7, then a full run ----
        do_reset();
        a_mask = 4'h9;
        a_seed_load = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("abort_pre_cnt", {16'd0, a_cnt}, 32'd7);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk("abort_busy", {31'd0, a_busy}, 32'h0);
        chk("abort_done", {31'd0, a_done}, 32'h0);
        chk("abort_cnt", {16'd0, a_cnt}, 32'd7);
        chk("abort_sig", {28'd0, a_sig}, {28'd0, model_sig(4'h1, 4'h9, 7)});
        a_abort = 1'b1;
        a_start = 1'b1;
        tick();
        a_abort = 1'b0;
        a_start = 1'b0;
        chk("abort_start_busy", {31'd0, a_busy}, 32'h0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("rerun_done", {31'd0, a_done}, 32'h1);
        chk("rerun_sig", {28'd0, a_sig}, {28'd0, model_sig(4'h1, 4'h9, 15)});

        // ---- B: MISR with constant responses ----
        foreach (vb[v]) begin
            do_reset();
            b_dut_out = vb[v].resp;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            chk("b_busy0", {31'd0, b_busy}, 32'h1);
            tick();
            chk("b_busy1", {31'd0, b_busy}, 32'h1);
            tick();
            chk("b_done", {31'd0, b_done}, 32'h1);
            chk("b_cnt", {16'd0, b_cnt}, 32'd2);
            chk("b_sig", {28'd0, b_sig}, {28'd0, vb[v].exp_sig});
`ifdef BIST_GOLDEN_CMP_EN
            chk("b_pass", {31'd0, b_pass}, {31'd0, (vb[v].exp_sig == 4'h3)});
`endif
        end

        // ---- C: LAT=2, busy for 5 cycles, exactly 3 captures ----
        do_reset();
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("c_busy", {31'd0, c_busy}, 32'h1);
            chk("c_not_done", {31'd0, c_done}, 32'h0);
            tick();
        end
        chk("c_done", {31'd0, c_done}, 32'h1);
        chk("c_busy_off", {31'd0, c_busy}, 32'h0);
        chk("c_cnt", {16'd0, c_cnt}, 32'd3);
        chk("c_sig", {28'd0, c_sig}, 32'h4);
        tick();
        chk("c_sig_hold", {28'd0, c_sig}, 32'h4);

        // ---- rst in the middle of a run ----
        a_start = 1'b1;
        b_dut_out = 4'h1;
        b_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_dut_in", {28'd0, a_dut_in}, 32'h0);
        chk("mid_rst_sig", {28'd0, a_sig}, 32'h0);
        chk("mid_rst_cnt", {16'd0, a_cnt}, 32'h0);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'h0);
        chk("mid_rst_b_done", {31'd0, b_done}, 32'h0);
        chk("mid_rst_b_sig", {28'd0, b_sig}, 32'h0);
`ifdef BIST_GOLDEN_CMP_EN
        chk("mid_rst_b_pass", {31'd0, b_pass}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
